// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared types and constants for the issue hazard unit.
// Default widths match the top-level parameter defaults.
package issue_pkg;
  localparam int ISSUE_W_MAX = 4;
  localparam int NSRC = 2;
  localparam int AW_DFLT = 7;
  localparam int LW_DFLT = 4;
  typedef logic [AW_DFLT-1:0] reg_addr_t;
  typedef logic [LW_DFLT-1:0] lat_t;
  typedef struct packed {
    logic vld;
    logic [NSRC-1:0] rd_en;
    reg_addr_t [NSRC-1:0] rs_addr;
    logic wr_en;
    reg_addr_t rd_addr;
    lat_t wr_lat;
  } slot_t;
endpackage

// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decode-to-scoreboard issue bundle handshake.
interface issue_scoreboard_if #(
  parameter int ISSUE_W = 2,
  parameter int AW = 7,
  parameter int LW = 4
);
  logic bnd_valid;
  logic bnd_ready;
  logic stall;
  logic [ISSUE_W-1:0] slot_vld;
  logic [ISSUE_W-1:0][1:0] rd_en;
  logic [ISSUE_W-1:0][1:0][AW-1:0] rs_addr;
  logic [ISSUE_W-1:0] wr_en;
  logic [ISSUE_W-1:0][AW-1:0] rd_addr;
  logic [ISSUE_W-1:0][LW-1:0] wr_lat;
  logic [ISSUE_W-1:0] issue_vec;
  modport master (
    output bnd_valid, slot_vld, rd_en, rs_addr, wr_en, rd_addr, wr_lat,
    input bnd_ready, stall, issue_vec
  );
  modport slave (
    input bnd_valid, slot_vld, rd_en, rs_addr, wr_en, rd_addr, wr_lat,
    output bnd_ready, stall, issue_vec
  );
endinterface

// File: rtl/issue_scoreboard_slot_hazard.sv
// slot_hazard: combinational RAW/WAW check of one slot against in-flight
// results and the older pending writers of the same bundle.
module slot_hazard
  import issue_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int AW = 7,
  parameter int LW = 4
) (
  input  logic [NSRC-1:0] rd_en,
  input  logic [NSRC-1:0][AW-1:0] rs_addr,
  input  logic wr_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [LW-1:0] wr_lat,
  input  logic [ISSUE_W-1:0] older_wr,
  input  logic [ISSUE_W-1:0][AW-1:0] older_rd,
  input  logic [NSRC-1:0][LW-1:0] src_cnt,
  input  logic [LW-1:0] dst_cnt,
  output logic blocked_raw,
  output logic blocked_waw
);
  always_comb begin
    blocked_raw = 1'b0;
    blocked_waw = wr_en && (dst_cnt > wr_lat);
    for (int s = 0; s < NSRC; s++)
      if (rd_en[s] && src_cnt[s] != '0) blocked_raw = 1'b1;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (older_wr[j]) begin
        for (int s = 0; s < NSRC; s++)
          if (rd_en[s] && rs_addr[s] == older_rd[j]) blocked_raw = 1'b1;
        if (wr_en && rd_addr == older_rd[j]) blocked_waw = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: N-wide in-order issue hazard unit with busy-latency scoreboard
// and tracked partial issue. Define ISSUE_SB_STATS_EN to add hazard statistics counters.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int AW = AW_DFLT,
  parameter int LW = LW_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  issue_scoreboard_if.slave bus
`ifdef ISSUE_SB_STATS_EN
  ,
  output logic [31:0] stat_raw_cyc,
  output logic [31:0] stat_waw_cyc,
  output logic [31:0] stat_partial_cyc
`endif
);
  logic [LW-1:0] cnt_q [2**AW];
  logic [ISSUE_W-1:0] done_q, done_d;
  logic [ISSUE_W-1:0] pending, raw, waw, blk, issue;
  logic ready, ok;
  assign pending = bus.slot_vld & ~done_q;
  assign blk = raw | waw;
  for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
    logic [ISSUE_W-1:0] older_wr;
    always_comb
      for (int j = 0; j < ISSUE_W; j++)
        older_wr[j] = (j < i) && pending[j] && bus.wr_en[j];
    slot_hazard #(.ISSUE_W(ISSUE_W), .AW(AW), .LW(LW)) u_hz (
      .rd_en(bus.rd_en[i]),
      .rs_addr(bus.rs_addr[i]),
      .wr_en(bus.wr_en[i]),
      .rd_addr(bus.rd_addr[i]),
      .wr_lat(bus.wr_lat[i]),
      .older_wr(older_wr),
      .older_rd(bus.rd_addr),
      .src_cnt({cnt_q[bus.rs_addr[i][1]], cnt_q[bus.rs_addr[i][0]]}),
      .dst_cnt(cnt_q[bus.rd_addr[i]]),
      .blocked_raw(raw[i]),
      .blocked_waw(waw[i])
    );
  end
  // A blocked pending slot cuts off every younger slot; finished/invalid ones do not.
  always_comb begin
    issue = '0;
    ok = bus.bnd_valid && !flush;
    for (int i = 0; i < ISSUE_W; i++) begin
      issue[i] = ok && pending[i] && !blk[i];
      if (pending[i] && blk[i]) ok = 1'b0;
    end
  end
  assign ready = bus.bnd_valid && !flush && (&(~bus.slot_vld | done_q | issue));
  assign done_d = ready ? '0 : (done_q | issue);
  assign bus.issue_vec = issue;
  assign bus.bnd_ready = ready;
  assign bus.stall = bus.bnd_valid && |(pending & blk);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 2**AW; r++) cnt_q[r] <= '0;
      done_q <= '0;
    end else if (flush) begin
      for (int r = 0; r < 2**AW; r++) cnt_q[r] <= '0;
      done_q <= '0;
    end else begin
      for (int r = 0; r < 2**AW; r++) cnt_q[r] <= (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
      for (int i = 0; i < ISSUE_W; i++)
        if (issue[i] && bus.wr_en[i] && bus.wr_lat[i] != '0) cnt_q[bus.rd_addr[i]] <= bus.wr_lat[i];
      done_q <= done_d;
    end
  end
`ifdef ISSUE_SB_STATS_EN
  logic first_raw, first_waw, found;
  always_comb begin
    first_raw = 1'b0;
    first_waw = 1'b0;
    found = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (!found && pending[i] && blk[i]) begin
        found = 1'b1;
        first_raw = raw[i];
        first_waw = !raw[i];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_raw_cyc <= '0;
      stat_waw_cyc <= '0;
      stat_partial_cyc <= '0;
    end else begin
      if (bus.bnd_valid && first_raw) stat_raw_cyc <= stat_raw_cyc + 32'd1;
      if (bus.bnd_valid && first_waw) stat_waw_cyc <= stat_waw_cyc + 32'd1;
      if (issue != '0 && !ready) stat_partial_cyc <= stat_partial_cyc + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: scenario tasks push expected issue outputs to a queue;
// each cycle the queue is drained and compared against the 2-wide or 4-wide instance.
module tb_issue_scoreboard;
  import issue_pkg::*;
  typedef struct {
    string name;
    logic [3:0] iv;
    logic rdy;
    logic st;
    bit w4;
    bit cst;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush2 = 1'b0;
  logic flush4 = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  localparam slot_t NOP = '0;
  issue_scoreboard_if #(.ISSUE_W(2)) b2();
  issue_scoreboard_if #(.ISSUE_W(4)) b4();
`ifdef ISSUE_SB_STATS_EN
  logic [31:0] r2, w2, p2, r4, w4, p4;
`endif
  issue_scoreboard #(.ISSUE_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(b2)
`ifdef ISSUE_SB_STATS_EN
    , .stat_raw_cyc(r2), .stat_waw_cyc(w2), .stat_partial_cyc(p2)
`endif
  );
  issue_scoreboard #(.ISSUE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(b4)
`ifdef ISSUE_SB_STATS_EN
    , .stat_raw_cyc(r4), .stat_waw_cyc(w4), .stat_partial_cyc(p4)
`endif
  );
  always #5 clk = ~clk;

  function automatic slot_t mk(logic [1:0] ren, int a0, int a1, logic wen, int rd, int lat);
    slot_t s;
    s.vld = 1'b1;
    s.rd_en = ren;
    s.rs_addr[0] = reg_addr_t'(a0);
    s.rs_addr[1] = reg_addr_t'(a1);
    s.wr_en = wen;
    s.rd_addr = reg_addr_t'(rd);
    s.wr_lat = lat_t'(lat);
    return s;
  endfunction

  task automatic set2(logic v, slot_t a, slot_t b);
    slot_t t[2];
    t = '{a, b};
    b2.bnd_valid = v;
    for (int i = 0; i < 2; i++) begin
      b2.slot_vld[i] = t[i].vld;
      b2.rd_en[i] = t[i].rd_en;
      b2.rs_addr[i] = t[i].rs_addr;
      b2.wr_en[i] = t[i].wr_en;
      b2.rd_addr[i] = t[i].rd_addr;
      b2.wr_lat[i] = t[i].wr_lat;
    end
  endtask

  task automatic set4(logic v, slot_t a, slot_t b, slot_t c, slot_t d);
    slot_t t[4];
    t = '{a, b, c, d};
    b4.bnd_valid = v;
    for (int i = 0; i < 4; i++) begin
      b4.slot_vld[i] = t[i].vld;
      b4.rd_en[i] = t[i].rd_en;
      b4.rs_addr[i] = t[i].rs_addr;
      b4.wr_en[i] = t[i].wr_en;
      b4.rd_addr[i] = t[i].rd_addr;
      b4.wr_lat[i] = t[i].wr_lat;
    end
  endtask

  task automatic push(string n, logic [3:0] iv, logic rdy, logic st, bit w4 = 1'b0, bit cst = 1'b1);
    exp_t e;
    e.name = n; e.iv = iv; e.rdy = rdy; e.st = st; e.w4 = w4; e.cst = cst;
    q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    logic [3:0] iv;
    logic rdy, st;
    @(negedge clk);
    while (q.size() != 0) begin
      e = q.pop_front();
      iv = e.w4 ? b4.issue_vec : {2'b00, b2.issue_vec};
      rdy = e.w4 ? b4.bnd_ready : b2.bnd_ready;
      st = e.w4 ? b4.stall : b2.stall;
      vectors++;
      if (iv !== e.iv) begin
        miscompares++;
        $display("FAIL %s issue_vec got %b want %b", e.name, iv, e.iv);
      end
      vectors++;
      if (rdy !== e.rdy) begin
        miscompares++;
        $display("FAIL %s bnd_ready got %b want %b", e.name, rdy, e.rdy);
      end
      if (e.cst) begin
        vectors++;
        if (st !== e.st) begin
          miscompares++;
          $display("FAIL %s stall got %b want %b", e.name, st, e.st);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set2(1'b0, NOP, NOP);
    set4(1'b0, NOP, NOP, NOP, NOP);
    push("reset2", 4'b0000, 1'b0, 1'b0);
    push("reset4", 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    push("idle", 4'b0000, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_independent();
    set2(1'b1, mk(2'b11, 2, 3, 1'b1, 1, 1), mk(2'b11, 5, 6, 1'b1, 4, 1));
    push("indep", 4'b0011, 1'b1, 1'b0);
    step();
    set2(1'b0, NOP, NOP);
    push("indep_idle", 4'b0000, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_empty();
    set2(1'b1, NOP, NOP);
    push("empty", 4'b0000, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_intra_raw();
    set2(1'b1, mk(2'b00, 0, 0, 1'b1, 5, 0), mk(2'b01, 5, 0, 1'b1, 8, 0));
    push("intra_c0", 4'b0001, 1'b0, 1'b1);
    step();
    push("intra_c1", 4'b0010, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_waw_bundle();
    set2(1'b1, mk(2'b00, 0, 0, 1'b1, 50, 0), mk(2'b00, 0, 0, 1'b1, 50, 0));
    push("wawb_c0", 4'b0001, 1'b0, 1'b1);
    step();
    push("wawb_c1", 4'b0010, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_inflight_raw();
    set2(1'b1, mk(2'b00, 0, 0, 1'b1, 7, 3), NOP);
    push("infl_prod", 4'b0001, 1'b1, 1'b0);
    step();
    set2(1'b1, mk(2'b01, 7, 0, 1'b1, 10, 0), NOP);
    for (int k = 0; k < 3; k++) begin
      push("infl_wait", 4'b0000, 1'b0, 1'b1);
      step();
    end
    push("infl_go", 4'b0001, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_waw_inflight();
    set2(1'b1, mk(2'b00, 0, 0, 1'b1, 9, 5), NOP);
    push("wawi_prod", 4'b0001, 1'b1, 1'b0);
    step();
    set2(1'b1, mk(2'b00, 0, 0, 1'b1, 9, 2), NOP);
    for (int k = 0; k < 3; k++) begin
      push("wawi_wait", 4'b0000, 1'b0, 1'b1);
      step();
    end
    push("wawi_go", 4'b0001, 1'b1, 1'b0);
    step();
    set2(1'b1, mk(2'b10, 0, 9, 1'b0, 0, 0), NOP);
    for (int k = 0; k < 2; k++) begin
      push("wawi_cnt2", 4'b0000, 1'b0, 1'b1);
      step();
    end
    push("wawi_read", 4'b0001, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_flush();
    slot_t w3, r3;
    w3 = mk(2'b00, 0, 0, 1'b1, 3, 4);
    r3 = mk(2'b01, 3, 0, 1'b0, 0, 0);
    set2(1'b1, w3, r3);
    push("flush_part", 4'b0001, 1'b0, 1'b1);
    step();
    flush2 = 1'b1;
    push("flush_pulse", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    flush2 = 1'b0;
    push("flush_reissue", 4'b0001, 1'b0, 1'b1);
    step();
    flush2 = 1'b1;
    push("flush_pulse2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    flush2 = 1'b0;
    set2(1'b1, r3, NOP);
    push("flush_cnt0", 4'b0001, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    set2(1'b1, mk(2'b00, 0, 0, 1'b1, 30, 0), mk(2'b00, 0, 0, 1'b1, 31, 0));
    push("b2b_a", 4'b0011, 1'b1, 1'b0);
    step();
    set2(1'b1, mk(2'b01, 30, 0, 1'b1, 32, 1), mk(2'b01, 31, 0, 1'b1, 33, 0));
    push("b2b_lat0", 4'b0011, 1'b1, 1'b0);
    step();
    set2(1'b1, mk(2'b01, 32, 0, 1'b0, 0, 0), NOP);
    push("b2b_lat1_wait", 4'b0000, 1'b0, 1'b1);
    step();
    push("b2b_lat1_go", 4'b0001, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    set2(1'b1, mk(2'b00, 0, 0, 1'b1, 60, 0), mk(2'b01, 60, 0, 1'b0, 0, 0));
    push("rstm_c0", 4'b0001, 1'b0, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (b2.issue_vec !== 2'b01) begin
      miscompares++;
      $display("FAIL rstm_async issue_vec got %b want 01", b2.issue_vec);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("rstm_again", 4'b0001, 1'b0, 1'b1);
    step();
    push("rstm_done", 4'b0010, 1'b1, 1'b0);
    step();
    set2(1'b0, NOP, NOP);
  endtask

  task automatic test_wide4();
    set4(1'b1, mk(2'b00, 0, 0, 1'b1, 20, 0), mk(2'b01, 21, 0, 1'b1, 22, 1), NOP,
         mk(2'b01, 20, 0, 1'b1, 23, 0));
    push("w4_c0", 4'b0011, 1'b0, 1'b1, 1'b1);
    step();
    push("w4_c1", 4'b1000, 1'b1, 1'b0, 1'b1);
    step();
    set4(1'b0, NOP, NOP, NOP, NOP);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    test_reset();
    test_independent();
    test_empty();
    test_intra_raw();
    test_waw_bundle();
    test_inflight_raw();
    test_waw_inflight();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_wide4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Parametrised N-wide in-order issue hazard unit. It holds a per-register busy-latency scoreboard and checks each slot of an incoming issue bundle for RAW and WAW hazards, both against in-flight results and against older slots in the same bundle. Each cycle it issues the longest hazard-free in-order prefix of the bundle's remaining slots and holds the bundle until every valid slot has issued. It sits between decode and the execute lanes and generalises the dual-issue stall logic to arbitrary width, with tracked partial issue.

## Interface
- ISSUE_W, 2: slots per bundle (1..4)
- AW, 7: register address width; scoreboard has 2**AW entries
- LW, 4: latency counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; clears scoreboard and partial-issue state
- bnd_valid  in  1  bundle present
- bnd_ready  out  1  bundle fully issued this cycle; upstream advances
- slot_vld  in  [ISSUE_W]  slot holds an instruction
- rd_en  in  [ISSUE_W][2]  source operand read enable
- rs_addr  in  [ISSUE_W][2][AW]  source register addresses
- wr_en  in  [ISSUE_W]  slot writes a destination
- rd_addr  in  [ISSUE_W][AW]  destination address
- wr_lat  in  [ISSUE_W][LW]  cycles until result is forwardable; 0 = same-cycle forward
- issue_vec  out  [ISSUE_W]  slots issuing this cycle (one-hot per slot)
- stall  out  1  bnd_valid and at least one pending slot blocked

## Operation
- Scoreboard: cnt[r] (LW bits) per register. Register r is busy while cnt[r] != 0.
- Pending slot i: slot_vld[i] and not done_q[i].
- Slot i is blocked when any of the following holds:
  - (a) RAW-inflight: an enabled source has cnt != 0.
  - (b) RAW-bundle: an enabled source equals rd_addr[j] of a pending slot j<i with wr_en[j].
  - (c) WAW-bundle: wr_en[i] and rd_addr[i] equals rd_addr[j] of a pending slot j<i with wr_en[j].
  - (d) WAW-inflight: wr_en[i] and cnt[rd_addr[i]] > wr_lat[i].
- issue_vec: pending slot i issues only if it is unblocked and every pending slot j<i also issues. Non-pending slots never block younger ones.
- No issue when bnd_valid=0 or flush=1.
- done_q[i] <= done_q[i] | issue_vec[i].
- bnd_ready = bnd_valid & !flush & (every valid slot is done_q or issuing now). When bnd_ready=1, done_q clears to 0.
- Scoreboard update each cycle: every nonzero cnt decrements by 1. For each issuing slot with wr_en and wr_lat != 0, cnt[rd_addr] <= wr_lat; the set wins over the decrement.
- Two issuing slots with the same rd_addr cannot occur, because (c) prevents it.
- flush: all cnt <= 0, done_q <= 0, issue_vec = 0, bnd_ready = 0.
- Empty bundle (bnd_valid=1, all slot_vld=0): bnd_ready=1 and issue_vec=0.

## Timing
- issue_vec, bnd_ready and stall are combinational from inputs and state; there are no registered outputs.
- Reset: all cnt=0 and done_q=0. Outputs then depend on inputs only: issue_vec=0, bnd_ready=0, stall=0 when bnd_valid=0.
- Producer issued in cycle t with wr_lat=L>0: a consumer is blocked in cycles t+1..t+L and may issue in t+L+1.
- With L=0 the consumer may issue in t+1. In the same bundle the consumer is always deferred to at least t+1.
- The bundle inputs must remain stable while bnd_valid=1 and bnd_ready=0.
- Reset asserted mid-bundle discards partial-issue state immediately.

## Configuration
- ISSUE_SB_STATS_EN defined:
  - Adds 32-bit wrapping counters stat_raw_cyc, stat_waw_cyc, stat_partial_cyc as outputs.
  - stat_raw_cyc and stat_waw_cyc increment in cycles where the oldest blocked pending slot is blocked by RAW or by WAW respectively. RAW takes precedence when both apply.
  - stat_partial_cyc increments in cycles where issue_vec != 0 and bnd_ready=0.
  - Counters reset to 0 on rst_n; flush does not clear them.
- ISSUE_SB_STATS_EN undefined: the counters and ports are absent and behaviour is otherwise identical.

## Structure
- Shared package issue_pkg holds:
  - localparams ISSUE_W_MAX=4 and NSRC=2
  - typedef reg_addr_t (logic [AW-1:0], default 7)
  - typedef lat_t
  - typedef slot_t as a packed struct {vld, rd_en[2], rs_addr[2], wr_en, rd_addr, wr_lat}
- Sub-module slot_hazard: purely combinational, one instance per slot. Inputs are the slot, the older pending slots masked by position, and the cnt values looked up for its sources and destination. Output is blocked_raw and blocked_waw.
- The scoreboard array and done_q stay in the top module.

## Test plan
- Independent pair: r1=r2+r3 and r4=r5+r6 with an idle scoreboard -> issue_vec=2'b11, bnd_ready=1 in the same cycle.
- Intra-bundle RAW: slot0 writes r5 (lat 0), slot1 reads r5 -> cycle 0 issue_vec=01, bnd_ready=0; cycle 1 issue_vec=10, bnd_ready=1.
- Inflight RAW: r7 issued at t with lat 3, consumer presented at t+1 -> stall=1 in t+1..t+3, issues at t+4.
- WAW-inflight: r9 has cnt=5, new writer of r9 with lat 2 -> blocked until cnt<=2 (3 cycles), then issues and cnt[r9]=2.
- Flush: partial bundle with done_q=01 and cnt[r3]=4, flush pulse -> next cycle all cnt=0 and done_q=0; a re-presented bundle issues from slot0.
- ISSUE_W=4 with slot2 invalid and slot3 dependent on slot0 -> cycle 0 issue_vec=0011, cycle 1 issue_vec=1000.
